// File: rtl/regfile_bypass_sb_if.sv
// Register file bus: writeback write port, decode read and alloc ports, hazard flags.
// Latency: not applicable; signal bundle only.
// Backpressure: none on the bus; decode stalls on busy1/busy2 and waits for init_done.
interface regfile_bypass_sb_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  we;
   logic [ADDR_WIDTH-1:0] A3;
   logic [DATA_WIDTH-1:0] WD3;
   logic [ADDR_WIDTH-1:0] A1;
   logic [ADDR_WIDTH-1:0] A2;
   logic [DATA_WIDTH-1:0] RD1;
   logic [DATA_WIDTH-1:0] RD2;
   logic                  alloc_valid;
   logic [ADDR_WIDTH-1:0] alloc_rd;
   logic                  busy1;
   logic                  busy2;
   logic                  init_done;

   // Pipeline side: drives writes, reads and allocations.
   modport master (
      output we, A3, WD3, A1, A2, alloc_valid, alloc_rd,
      input  RD1, RD2, busy1, busy2, init_done
   );

   // Register file side.
   modport slave (
      input  we, A3, WD3, A1, A2, alloc_valid, alloc_rd,
      output RD1, RD2, busy1, busy2, init_done
   );
endinterface

// File: rtl/regfile_bypass_sb.sv
// Register file: 2 async reads, 1 sync write, x0 = 0, reset sweep, WB->ID bypass, pending scoreboard.
// Latency: reads and busy flags are combinational; writes and scoreboard updates land at the next posedge.
// Backpressure: none accepted; writes/allocs are ignored during the 2**ADDR_WIDTH-cycle clear sweep.
module regfile_bypass_sb #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int BYPASS     = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_bypass_sb_if.slave   rf
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {CLEAR, READY} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  init_done_q, init_done_d;
   logic [DEPTH-1:0]      pending_q, pending_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_dat;

   logic                  byp1, byp2;

   // Next state: the sweep owns the write port in CLEAR, writeback owns it in READY.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      init_done_d = init_done_q;
      pending_d   = pending_q;
      wr_en       = 1'b0;
      wr_addr     = rf.A3;
      wr_dat      = rf.WD3;
      if (state_q == CLEAR) begin
         wr_en   = 1'b1;
         wr_addr = idx_q;
         wr_dat  = '0;
         idx_d   = idx_q + ADDR_WIDTH'(1);
         if (idx_q == {ADDR_WIDTH{1'b1}}) begin
            state_d     = READY;
            init_done_d = 1'b1;
         end
      end else begin
         if (rf.we && (rf.A3 != '0)) begin
            wr_en               = 1'b1;
            pending_d[rf.A3]    = 1'b0;
         end
         // Applied after the clear so a new producer supersedes the retiring one.
         if (rf.alloc_valid && (rf.alloc_rd != '0)) begin
            pending_d[rf.alloc_rd] = 1'b1;
         end
      end
      pending_d[0] = 1'b0;
   end

   // Control state and scoreboard; reset restarts the sweep from index 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLEAR;
         idx_q       <= '0;
         init_done_q <= 1'b0;
         pending_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         init_done_q <= init_done_d;
         pending_q   <= pending_d;
      end
   end

   // Storage array; no reset here because the sweep clears every entry.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem_q[wr_addr] <= wr_dat;
      end
   end

   // Read ports: x0 and the CLEAR state read zero, a same-cycle write is forwarded when enabled.
   always_comb begin
      byp1     = (BYPASS != 0) && rf.we && (rf.A3 == rf.A1);
      byp2     = (BYPASS != 0) && rf.we && (rf.A3 == rf.A2);
      rf.RD1   = '0;
      rf.RD2   = '0;
      rf.busy1 = 1'b0;
      rf.busy2 = 1'b0;
      if ((state_q == READY) && (rf.A1 != '0)) begin
         rf.RD1   = byp1 ? rf.WD3 : mem_q[rf.A1];
         rf.busy1 = pending_q[rf.A1] && !byp1;
      end
      if ((state_q == READY) && (rf.A2 != '0)) begin
         rf.RD2   = byp2 ? rf.WD3 : mem_q[rf.A2];
         rf.busy2 = pending_q[rf.A2] && !byp2;
      end
   end

   assign rf.init_done = init_done_q;

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: bypassing and non-bypassing instances share one stimulus stream.
// Directed plan steps followed by a random phase, all checked against a behavioural model.
module tb_regfile_bypass_sb;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          we;
   logic [AW-1:0] A3, A1, A2, alloc_rd;
   logic [DW-1:0] WD3;
   logic          alloc_valid;

   always #5 clk = ~clk;

   regfile_bypass_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_b ();
   regfile_bypass_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_n ();

   assign if_b.we = we;           assign if_n.we = we;
   assign if_b.A3 = A3;           assign if_n.A3 = A3;
   assign if_b.WD3 = WD3;         assign if_n.WD3 = WD3;
   assign if_b.A1 = A1;           assign if_n.A1 = A1;
   assign if_b.A2 = A2;           assign if_n.A2 = A2;
   assign if_b.alloc_valid = alloc_valid;  assign if_n.alloc_valid = alloc_valid;
   assign if_b.alloc_rd = alloc_rd;        assign if_n.alloc_rd = alloc_rd;

   regfile_bypass_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .rf(if_b));
   regfile_bypass_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(0)) dut_n (
      .clk(clk), .rst(rst), .rf(if_n));

   // Behavioural model: a reset clears the array at once and blocks traffic for DEPTH cycles.
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_pend [DEPTH];
   int            clear_left = DEPTH;
   int            n_cmp = 0;
   int            n_err = 0;
   bit            chk_en = 1'b0;
   int            nsw;

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
      if (clear_left != 0 || a == 0) return '0;
      if (byp && we && A3 == a) return WD3;
      return m_mem[a];
   endfunction

   function automatic logic [DW-1:0] exp_busy(input logic [AW-1:0] a, input bit byp);
      if (clear_left != 0 || a == 0) return '0;
      return {{(DW-1){1'b0}}, m_pend[a] && !(byp && we && A3 == a)};
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      chk("rd1_byp",   if_b.RD1, exp_rd(A1, 1'b1));
      chk("rd2_byp",   if_b.RD2, exp_rd(A2, 1'b1));
      chk("busy1_byp", {31'd0, if_b.busy1}, exp_busy(A1, 1'b1));
      chk("busy2_byp", {31'd0, if_b.busy2}, exp_busy(A2, 1'b1));
      chk("init_byp",  {31'd0, if_b.init_done}, {31'd0, clear_left == 0});
      chk("rd1_nobyp", if_n.RD1, exp_rd(A1, 1'b0));
      chk("rd2_nobyp", if_n.RD2, exp_rd(A2, 1'b0));
      chk("busy1_nobyp", {31'd0, if_n.busy1}, exp_busy(A1, 1'b0));
      chk("busy2_nobyp", {31'd0, if_n.busy2}, exp_busy(A2, 1'b0));
      chk("init_nobyp",  {31'd0, if_n.init_done}, {31'd0, clear_left == 0});
   endtask

   task automatic model_update();
      if (rst) begin
         clear_left = DEPTH;
         for (int r = 0; r < DEPTH; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
         end
      end else if (clear_left != 0) begin
         clear_left--;
      end else begin
         if (we && A3 != 0) begin
            m_mem[A3]  = WD3;
            m_pend[A3] = 1'b0;
         end
         if (alloc_valid && alloc_rd != 0) m_pend[alloc_rd] = 1'b1;
      end
   endtask

   // One cycle: check at the falling edge, advance the model at the rising edge.
   task automatic tick();
      @(negedge clk);
      if (chk_en) check_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (!if_b.init_done && n < 40) begin
         tick();
         n++;
      end
   endtask

   function automatic logic [AW-1:0] pick_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
      return AW'($urandom_range(0, 7));
   endfunction

   initial begin
      rst = 1'b1; we = 1'b0; A3 = '0; WD3 = '0; A1 = '0; A2 = '0;
      alloc_valid = 1'b0; alloc_rd = '0;
      tick();
      chk_en = 1'b1;
      #1;
      chk("reset_init_done", {31'd0, if_b.init_done}, 32'd0);
      chk("reset_rd1", if_b.RD1, 32'd0);

      // Plan 1: sweep length, write during CLEAR ignored, all registers zero.
      rst = 1'b0; we = 1'b1; A3 = 5'd6; WD3 = 32'hFFFF_FFFF;
      alloc_valid = 1'b1; alloc_rd = 5'd6;
      wait_init(nsw);
      chk("sweep_len", nsw, 32'd32);
      we = 1'b0; alloc_valid = 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
         A1 = AW'(r); A2 = AW'(DEPTH - 1 - r);
         tick();
      end
      A1 = 5'd6; #1;
      chk("clear_wr_ignored", if_b.RD1, 32'd0);
      chk("clear_alloc_ignored", {31'd0, if_b.busy1}, 32'd0);

      // Plan 2: reset reasserted at sweep cycle 10.
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (10) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      wait_init(nsw);
      chk("midsweep_len", nsw, 32'd32);

      // Plan 3: basic write/read, x0 never written.
      we = 1'b1; A3 = 5'd5; WD3 = 32'hDEAD_BEEF; A1 = 5'd0; tick();
      we = 1'b0; A1 = 5'd5; #1;
      chk("wr_rd5", if_b.RD1, 32'hDEAD_BEEF);
      tick();
      we = 1'b1; A3 = 5'd0; WD3 = 32'h1234; A1 = 5'd0; tick();
      we = 1'b0; #1;
      chk("x0_rd", if_b.RD1, 32'd0);
      chk("x0_busy", {31'd0, if_b.busy1}, 32'd0);
      tick();

      // Plan 4: same-cycle bypass versus plain read.
      we = 1'b1; A3 = 5'd7; WD3 = 32'h11; tick();
      WD3 = 32'hA5A5_A5A5; A1 = 5'd7; A2 = 5'd7; #1;
      chk("byp_rd1", if_b.RD1, 32'hA5A5_A5A5);
      chk("byp_rd2", if_b.RD2, 32'hA5A5_A5A5);
      chk("nobyp_rd1_old", if_n.RD1, 32'h11);
      chk("nobyp_rd2_old", if_n.RD2, 32'h11);
      tick();
      we = 1'b0; #1;
      chk("nobyp_rd1_new", if_n.RD1, 32'hA5A5_A5A5);
      tick();

      // Plan 5: scoreboard set, clear, and set-wins collision.
      alloc_valid = 1'b1; alloc_rd = 5'd9; tick();
      alloc_valid = 1'b0; A1 = 5'd9; #1;
      chk("sb_busy_byp", {31'd0, if_b.busy1}, 32'd1);
      chk("sb_busy_nobyp", {31'd0, if_n.busy1}, 32'd1);
      we = 1'b1; A3 = 5'd9; WD3 = 32'h99; #1;
      chk("sb_wb_byp", {31'd0, if_b.busy1}, 32'd0);
      chk("sb_wb_nobyp", {31'd0, if_n.busy1}, 32'd1);
      tick();
      we = 1'b0; #1;
      chk("sb_cleared", {31'd0, if_b.busy1}, 32'd0);
      alloc_valid = 1'b1; alloc_rd = 5'd9; we = 1'b1; A3 = 5'd9; tick();
      alloc_valid = 1'b0; we = 1'b0; #1;
      chk("sb_set_wins", {31'd0, if_n.busy1}, 32'd1);
      tick();

      // Plan 6: reset in the middle of operation.
      we = 1'b1; A3 = 5'd3; WD3 = 32'h55; tick();
      we = 1'b0; alloc_valid = 1'b1; alloc_rd = 5'd3; tick();
      alloc_rd = 5'd4; tick();
      alloc_valid = 1'b0; A1 = 5'd3; A2 = 5'd4; tick();
      rst = 1'b1; tick(); rst = 1'b0;
      wait_init(nsw);
      #1;
      chk("rst_busy3", {31'd0, if_b.busy1}, 32'd0);
      chk("rst_busy4", {31'd0, if_b.busy2}, 32'd0);
      chk("rst_rd3", if_b.RD1, 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         rst         = ($urandom_range(0, 399) == 0);
         we          = $urandom_range(0, 1) == 1;
         A3          = pick_addr();
         WD3         = $urandom;
         A1          = pick_addr();
         A2          = ($urandom_range(0, 4) == 0) ? A1 : pick_addr();
         alloc_valid = $urandom_range(0, 2) == 0;
         alloc_rd    = ($urandom_range(0, 3) == 0) ? A3 : pick_addr();
         tick();
      end
      rst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
